// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: PC/stage enables, bubble inserts, halt tracking
// and saturating stall/flush statistics.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             d_ren_ex,
    input  logic [4:0]       wsel_ex,
    input  logic [4:0]       rsel1_dc,
    input  logic [4:0]       rsel2_dc,
    input  logic             d_ren_mem,
    input  logic             d_wen_mem,
    input  logic             br_taken_mem,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             pipe1_en,
    output logic             pipe2_en,
    output logic             pipe3_en,
    output logic             pipe4_en,
    output logic             flushed1,
    output logic             flushed2,
    output logic             flushed3,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_n;

    logic dreq;
    logic freeze;
    logic lduse;
    logic br_take;
    logic stall_inc;

    assign dreq   = d_ren_mem | d_wen_mem;
    assign freeze = dreq & ~dhit;
    assign lduse  = d_ren_ex & (wsel_ex != 5'd0) &
                    ((wsel_ex == rsel1_dc) | (wsel_ex == rsel2_dc));

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Next state and enables/flushes, events in priority order
    always_comb begin
        state_n  = state;
        pc_en    = 1'b1;
        pipe1_en = 1'b1;
        pipe2_en = 1'b1;
        pipe3_en = 1'b1;
        pipe4_en = 1'b1;
        flushed1 = 1'b0;
        flushed2 = 1'b0;
        flushed3 = 1'b0;
        br_take  = 1'b0;

        case (state)
            HALTED: begin
                pc_en    = 1'b0;
                pipe1_en = 1'b0;
                pipe2_en = 1'b0;
                pipe3_en = 1'b0;
                pipe4_en = 1'b0;
            end
            default: begin
                if (freeze) begin
                    state_n  = DWAIT;
                    pc_en    = 1'b0;
                    pipe1_en = 1'b0;
                    pipe2_en = 1'b0;
                    pipe3_en = 1'b0;
                    pipe4_en = 1'b0;
                end else if (halt_mem) begin
                    // Let the halt retire into mem_wb, squash everything behind it
                    state_n  = HALTED;
                    pc_en    = 1'b0;
                    pipe1_en = 1'b0;
                    pipe2_en = 1'b0;
                    pipe3_en = 1'b0;
                    flushed3 = 1'b1;
                end else begin
                    state_n = RUN;
                    if (br_taken_mem) begin
                        br_take  = 1'b1;
                        flushed1 = 1'b1;
                        flushed2 = 1'b1;
                        flushed3 = 1'b1;
                    end else if (lduse) begin
                        pc_en    = 1'b0;
                        pipe1_en = 1'b0;
                        flushed2 = 1'b1;
                    end else if (!ihit) begin
                        pc_en    = 1'b0;
                        pipe1_en = 1'b0;
                        flushed1 = 1'b1;
                    end
                end
            end
        endcase
    end

    assign halted    = (state == HALTED);
    assign stall_inc = (state != HALTED) & ~pc_en;

    // Saturating statistics counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_take && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a priority-table model.
module tb_pipe_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, d_ren_ex, d_ren_mem, d_wen_mem, br_taken_mem, halt_mem;
    logic [4:0] wsel_ex, rsel1_dc, rsel2_dc;

    logic        pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
    logic        flushed1, flushed2, flushed3, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_pipe1_en, s_pipe2_en, s_pipe3_en, s_pipe4_en;
    logic        s_flushed1, s_flushed2, s_flushed3, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int ntests = 0;
    int nfail  = 0;

    // Model state: halted flag plus unbounded-then-clamped counters
    bit m_halted;
    int m_stall16, m_flush16, m_stall4, m_flush4;

    always #5 CLK = ~CLK;

    pipe_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .d_ren_ex(d_ren_ex),
        .wsel_ex(wsel_ex), .rsel1_dc(rsel1_dc), .rsel2_dc(rsel2_dc),
        .d_ren_mem(d_ren_mem), .d_wen_mem(d_wen_mem), .br_taken_mem(br_taken_mem),
        .halt_mem(halt_mem), .pc_en(pc_en), .pipe1_en(pipe1_en), .pipe2_en(pipe2_en),
        .pipe3_en(pipe3_en), .pipe4_en(pipe4_en), .flushed1(flushed1),
        .flushed2(flushed2), .flushed3(flushed3), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_s (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .d_ren_ex(d_ren_ex),
        .wsel_ex(wsel_ex), .rsel1_dc(rsel1_dc), .rsel2_dc(rsel2_dc),
        .d_ren_mem(d_ren_mem), .d_wen_mem(d_wen_mem), .br_taken_mem(br_taken_mem),
        .halt_mem(halt_mem), .pc_en(s_pc_en), .pipe1_en(s_pipe1_en),
        .pipe2_en(s_pipe2_en), .pipe3_en(s_pipe3_en), .pipe4_en(s_pipe4_en),
        .flushed1(s_flushed1), .flushed2(s_flushed2), .flushed3(s_flushed3),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    wire [7:0] outs   = {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
                         flushed1, flushed2, flushed3};
    wire [7:0] s_outs = {s_pc_en, s_pipe1_en, s_pipe2_en, s_pipe3_en, s_pipe4_en,
                         s_flushed1, s_flushed2, s_flushed3};

    // Output vector order: {pc_en, pipe1..4_en, flushed1..3}
    localparam logic [7:0] O_ALL0  = 8'b0000_0000;
    localparam logic [7:0] O_NORM  = 8'b1111_1000;
    localparam logic [7:0] O_HALT  = 8'b0000_1001;
    localparam logic [7:0] O_BR    = 8'b1111_1111;
    localparam logic [7:0] O_LDUSE = 8'b0011_1010;
    localparam logic [7:0] O_MISS  = 8'b0011_1100;

    typedef enum int {EV_NONE, EV_HALTED, EV_FREEZE, EV_HALT, EV_BR, EV_LDUSE, EV_MISS} ev_t;

    function automatic ev_t cur_event(input bit h);
        bit lu;
        lu = d_ren_ex && (wsel_ex != 5'd0) && (wsel_ex == rsel1_dc || wsel_ex == rsel2_dc);
        if (h)                                 return EV_HALTED;
        if ((d_ren_mem || d_wen_mem) && !dhit) return EV_FREEZE;
        if (halt_mem)                          return EV_HALT;
        if (br_taken_mem)                      return EV_BR;
        if (lu)                                return EV_LDUSE;
        if (!ihit)                             return EV_MISS;
        return EV_NONE;
    endfunction

    function automatic logic [7:0] exp_outs(input bit h);
        case (cur_event(h))
            EV_HALTED, EV_FREEZE: return O_ALL0;
            EV_HALT:              return O_HALT;
            EV_BR:                return O_BR;
            EV_LDUSE:             return O_LDUSE;
            EV_MISS:              return O_MISS;
            default:              return O_NORM;
        endcase
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_halted  <= 1'b0;
            m_stall16 <= 0; m_flush16 <= 0;
            m_stall4  <= 0; m_flush4  <= 0;
        end else if (!m_halted) begin
            ev_t e;
            e = cur_event(1'b0);
            if (exp_outs(1'b0) >> 7 == 8'd0) begin
                m_stall16 <= (m_stall16 < 65535) ? m_stall16 + 1 : m_stall16;
                m_stall4  <= (m_stall4  < 15)    ? m_stall4  + 1 : m_stall4;
            end
            if (e == EV_BR) begin
                m_flush16 <= (m_flush16 < 65535) ? m_flush16 + 1 : m_flush16;
                m_flush4  <= (m_flush4  < 15)    ? m_flush4  + 1 : m_flush4;
            end
            if (e == EV_HALT) m_halted <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model
    always @(negedge CLK) begin
        logic [7:0] e;
        e = exp_outs(m_halted);
        chk("outs", 32'(outs), 32'(e));
        chk("s_outs", 32'(s_outs), 32'(e));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("s_halted", 32'(s_halted), 32'(m_halted));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall16));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush16));
        chk("s_stall_cnt", 32'(s_stall_cnt), 32'(m_stall4));
        chk("s_flush_cnt", 32'(s_flush_cnt), 32'(m_flush4));
    end

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1; d_ren_ex = 1'b0; d_ren_mem = 1'b0; d_wen_mem = 1'b0;
        br_taken_mem = 1'b0; halt_mem = 1'b0;
        wsel_ex = 5'd0; rsel1_dc = 5'd0; rsel2_dc = 5'd0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_inputs();
        ihit         = ($urandom_range(0, 9) < 8);
        dhit         = $urandom_range(0, 1) == 1;
        d_ren_mem    = ($urandom_range(0, 9) < 2);
        d_wen_mem    = ($urandom_range(0, 9) < 1);
        d_ren_ex     = $urandom_range(0, 1) == 1;
        br_taken_mem = ($urandom_range(0, 9) < 1);
        halt_mem     = ($urandom_range(0, 49) == 0);
        wsel_ex      = 5'($urandom_range(0, 3));
        rsel1_dc     = 5'($urandom_range(0, 3));
        rsel2_dc     = 5'($urandom_range(0, 3));
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        repeat (2) cyc();
        chk("rst_outs", 32'(outs), 32'(O_NORM));
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        nRST = 1'b1;
        cyc();

        // Load-use stall, then zero destination must not stall
        ihit = 1'b1; d_ren_ex = 1'b1; wsel_ex = 5'd5; rsel1_dc = 5'd5;
        #2;
        chk("lduse_outs", 32'(outs), 32'(O_LDUSE));
        chk("lduse_model", 32'(exp_outs(1'b0)), 32'(O_LDUSE));
        cyc();
        chk("lduse_stall", 32'(stall_cnt), 32'd1);
        wsel_ex = 5'd0; rsel1_dc = 5'd0;
        #2;
        chk("r0_outs", 32'(outs), 32'(O_NORM));
        cyc();
        chk("r0_stall", 32'(stall_cnt), 32'd1);
        idle();

        // Three-cycle data wait, then release
        d_ren_mem = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("dwait_outs", 32'(outs), 32'(O_ALL0));
            cyc();
        end
        dhit = 1'b1;
        #2;
        chk("dhit_outs", 32'(outs), 32'(O_NORM));
        cyc();
        idle();
        chk("dwait_stall", 32'(stall_cnt), 32'd4);

        // Branch beats load-use and fetch miss
        br_taken_mem = 1'b1; d_ren_ex = 1'b1; wsel_ex = 5'd3; rsel2_dc = 5'd3; ihit = 1'b0;
        #2;
        chk("br_outs", 32'(outs), 32'(O_BR));
        chk("br_model", 32'(exp_outs(1'b0)), 32'(O_BR));
        cyc();
        idle();
        chk("br_flush", 32'(flush_cnt), 32'd1);
        chk("br_stall", 32'(stall_cnt), 32'd4);

        // Saturation of the 4-bit instance
        ihit = 1'b0;
        repeat (20) cyc();
        idle();
        chk("sat_s_stall", 32'(s_stall_cnt), 32'd15);
        chk("sat_stall", 32'(stall_cnt), 32'd24);

        // Halt then ignore everything
        halt_mem = 1'b1;
        #2;
        chk("halt_outs", 32'(outs), 32'(O_HALT));
        cyc();
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            #2;
            chk("halted_outs", 32'(outs), 32'(O_ALL0));
            chk("halted_flag", 32'(halted), 32'd1);
            cyc();
        end
        chk("halt_stall", 32'(stall_cnt), 32'd25);

        // Asynchronous reset out of HALTED
        #2;
        idle();
        nRST = 1'b0;
        #1;
        chk("rsth_halted", 32'(halted), 32'd0);
        chk("rsth_stall", 32'(stall_cnt), 32'd0);
        chk("rsth_flush", 32'(flush_cnt), 32'd0);
        chk("rsth_outs", 32'(outs), 32'(O_NORM));
        cyc();
        nRST = 1'b1;

        // First edge after reset is a normal RUN edge
        ihit = 1'b0;
        cyc();
        idle();
        chk("post_rst_stall", 32'(stall_cnt), 32'd1);

        // Asynchronous reset out of DWAIT
        d_wen_mem = 1'b1; dhit = 1'b0;
        cyc();
        cyc();
        chk("dw_stall", 32'(stall_cnt), 32'd3);
        #2;
        idle();
        nRST = 1'b0;
        #1;
        chk("rstd_stall", 32'(stall_cnt), 32'd0);
        chk("rstd_outs", 32'(outs), 32'(O_NORM));
        cyc();
        nRST = 1'b1;
        #2;
        chk("rstd_run_outs", 32'(outs), 32'(O_NORM));
        cyc();

        // Randomized traffic with periodic recovery from halt
        begin
            int halt_age;
            halt_age = 0;
            for (int i = 0; i < 4000; i++) begin
                if (m_halted) halt_age++;
                if (halt_age > 4 + int'($urandom_range(0, 6)) || $urandom_range(0, 299) == 0) begin
                    idle();
                    nRST = 1'b0;
                    halt_age = 0;
                    cyc();
                    nRST = 1'b1;
                end else begin
                    rand_inputs();
                    cyc();
                end
            end
        end

        idle();
        cyc();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
